// File: rtl/powlib_busdecarb.sv
// N-master to M-slave switch for the powlib packed-word bus: address decode, per-slave
// round-robin arbitration, one-word output register per slave, unmapped words sunk and counted.
module powlib_busdecarb #(
    parameter int                    B_WRS   = 3,
    parameter int                    B_RDS   = 3,
    parameter int                    B_AW    = 32,
    parameter int                    B_DW    = 40,
    parameter logic [B_AW*B_RDS-1:0] B_BASES = {B_RDS{32'h0}},
    parameter logic [B_AW*B_RDS-1:0] B_SIZES = {B_RDS{32'hFFFF}},
    parameter int                    ERRW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [B_AW*B_WRS-1:0]  wraddrs,
    input  logic [B_DW*B_WRS-1:0]  wrdatas,
    input  logic [B_WRS-1:0]       wrvlds,
    output logic [B_WRS-1:0]       wrrdys,
    output logic [B_AW*B_RDS-1:0]  rdaddrs,
    output logic [B_DW*B_RDS-1:0]  rddatas,
    output logic [B_RDS-1:0]       rdvlds,
    input  logic [B_RDS-1:0]       rdrdys,
    output logic [ERRW-1:0]        errcnt,
    output logic                   errvld
);

    localparam int PW = (B_WRS > 1) ? $clog2(B_WRS) : 1;
    localparam int CW = $clog2(B_WRS + 1);
    localparam int SW = ((ERRW > CW) ? ERRW : CW) + 1;
    localparam logic [SW-1:0] ERR_MAX = SW'({ERRW{1'b1}});

    logic [B_RDS-1:0] hit_oh [B_WRS];
    logic [B_WRS-1:0] unmapped;
    logic [PW-1:0]    ptr     [B_RDS];
    logic [PW-1:0]    gnt_idx [B_RDS];
    logic [PW-1:0]    ptr_nxt [B_RDS];
    logic [B_RDS-1:0] gnt_any;
    logic [B_RDS-1:0] ld;
    logic [B_WRS-1:0] granted;
    logic [CW-1:0]    unm_cnt;
    logic [SW-1:0]    err_sum;

    // Window top is formed one bit wider so base+size never wraps past the address space.
    function automatic logic in_window(input logic [B_AW-1:0] addr,
                                       input logic [B_AW-1:0] base,
                                       input logic [B_AW-1:0] size);
        logic [B_AW:0] top;
        top = {1'b0, base} + {1'b0, size};
        return (addr >= base) && ({1'b0, addr} <= top);
    endfunction

    // Scanning slaves from the top down leaves the lowest matching slave as the hit.
    always_comb begin
        for (int i = 0; i < B_WRS; i++) begin
            hit_oh[i] = '0;
            for (int j = B_RDS - 1; j >= 0; j--) begin
                if (in_window(wraddrs[B_AW*i +: B_AW], B_BASES[B_AW*j +: B_AW],
                              B_SIZES[B_AW*j +: B_AW])) begin
                    hit_oh[i]    = '0;
                    hit_oh[i][j] = 1'b1;
                end
            end
            unmapped[i] = (hit_oh[i] == '0);
        end
    end

    always_comb begin : arb
        int idx;
        int gidx;
        granted = '0;
        for (int j = 0; j < B_RDS; j++) begin
            ld[j]      = !rdvlds[j] || rdrdys[j];
            gnt_any[j] = 1'b0;
            gidx       = 0;
            for (int k = 0; k < B_WRS; k++) begin
                idx = int'(ptr[j]) + k;
                if (idx >= B_WRS) idx = idx - B_WRS;
                if (!gnt_any[j] && wrvlds[idx] && hit_oh[idx][j]) begin
                    gnt_any[j] = 1'b1;
                    gidx       = idx;
                end
            end
            gnt_idx[j] = PW'(gidx);
            ptr_nxt[j] = (gidx == B_WRS - 1) ? '0 : PW'(gidx + 1);
            if (gnt_any[j] && ld[j]) granted[gidx] = 1'b1;
        end
    end

    // Handshake: a word moves when vld and rdy are both high on a rising edge. wrrdys is
    // combinational and may depend on wrvlds in the same cycle; held low while in reset.
    assign wrrdys = rst ? ((wrvlds & unmapped) | granted) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdaddrs <= '0;
            rddatas <= '0;
            rdvlds  <= '0;
            for (int j = 0; j < B_RDS; j++) ptr[j] <= '0;
        end else begin
            for (int j = 0; j < B_RDS; j++) begin
                if (gnt_any[j] && ld[j]) begin
                    rdaddrs[B_AW*j +: B_AW] <= wraddrs[B_AW*int'(gnt_idx[j]) +: B_AW];
                    rddatas[B_DW*j +: B_DW] <= wrdatas[B_DW*int'(gnt_idx[j]) +: B_DW];
                    rdvlds[j]               <= 1'b1;
                    ptr[j]                  <= ptr_nxt[j];
                end else if (rdrdys[j]) begin
                    rdvlds[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        unm_cnt = '0;
        for (int i = 0; i < B_WRS; i++) begin
            if (wrvlds[i] && unmapped[i]) unm_cnt = unm_cnt + CW'(1);
        end
        err_sum = SW'(errcnt) + SW'(unm_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errcnt <= '0;
            errvld <= 1'b0;
        end else begin
            errcnt <= (err_sum > ERR_MAX) ? '1 : err_sum[ERRW-1:0];
            errvld <= (unm_cnt != '0);
        end
    end

endmodule
